// File: rtl/bias_ctrl_pkg.sv
// Shared types and constants for the bias update controller.
// FSM encoding, batch counter width and saturation limits.
package bias_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_CALC = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_ACC  = ST_ACC,
    S_CALC = ST_CALC,
    S_OUT  = ST_OUT
  } state_t;

  // Top two bits of a WIDTH+1 result disagree on overflow.
  localparam logic [1:0] OVF_POS = 2'b01;
  localparam logic [1:0] OVF_NEG = 2'b10;

  // Saturation limits expressed as sign bit plus fill bit,
  // so any WIDTH can build {MSB, {WIDTH-1{FILL}}}.
  localparam logic SAT_MAX_MSB  = 1'b0;
  localparam logic SAT_MAX_FILL = 1'b1;
  localparam logic SAT_MIN_MSB  = 1'b1;
  localparam logic SAT_MIN_FILL = 1'b0;

endpackage

// File: rtl/sat_sub.sv
// Saturating signed subtract: y = sat(a - b) at WIDTH bits.
// Ports: a, b (signed WIDTH) in; y (signed WIDTH) out.
module sat_sub
  import bias_ctrl_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] y
);

  localparam logic [WIDTH-1:0] HI =
    {SAT_MAX_MSB, {(WIDTH-1){SAT_MAX_FILL}}};
  localparam logic [WIDTH-1:0] LO =
    {SAT_MIN_MSB, {(WIDTH-1){SAT_MIN_FILL}}};

  logic signed [WIDTH:0] diff;

  assign diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};

  always_comb begin
    y = diff[WIDTH-1:0];
    unique case (diff[WIDTH:WIDTH-1])
      OVF_POS: y = HI;
      OVF_NEG: y = LO;
      default: y = diff[WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/bias_upd_ctrl.sv
// Batch gradient bias update: drives an external accumulator, then
// emits sat(bias - sum>>>LR_SHIFT). Ports: start/bias_in, d_*, acc_*, upd_*, busy.
module bias_upd_ctrl
  import bias_ctrl_pkg::*;
#(
  parameter int WIDTH    = DATA_W,
  parameter int BATCH    = 8,
  parameter int LR_SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] bias_in,
  input  logic                    d_valid,
  input  logic signed [WIDTH-1:0] d_data,
  output logic                    d_ready,
  output logic                    acc_en,
  output logic signed [WIDTH-1:0] acc_i,
  input  logic signed [WIDTH-1:0] acc_o,
  output logic                    upd_valid,
  input  logic                    upd_ready,
  output logic signed [WIDTH-1:0] upd_bias,
  output logic                    busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BATCH - 1);

  state_t                  state;
  state_t                  state_n;
  logic [CNT_W-1:0]        cnt;
  logic signed [WIDTH-1:0] bias_reg;
  logic signed [WIDTH-1:0] acc_sh;
  logic signed [WIDTH-1:0] sat_y;

  assign acc_sh = acc_o >>> LR_SHIFT;

  sat_sub #(
    .WIDTH(WIDTH)
  ) u_sat (
    .a(bias_reg),
    .b(acc_sh),
    .y(sat_y)
  );

  always_comb begin
    state_n   = state;
    d_ready   = 1'b0;
    acc_en    = 1'b0;
    acc_i     = '0;
    upd_valid = 1'b0;
    busy      = (state != S_IDLE);
    unique case (state)
      S_IDLE: begin
        if (start) state_n = S_ACC;
      end
      S_ACC: begin
        d_ready = 1'b1;
        // First sample loads, later ones add.
        acc_en  = (cnt != '0);
        if (d_valid) begin
          acc_i = d_data;
          if (cnt == LAST) state_n = S_CALC;
        end
      end
      S_CALC: begin
        acc_en  = 1'b1;
        state_n = S_OUT;
      end
      S_OUT: begin
        acc_en    = 1'b1;
        upd_valid = 1'b1;
        if (upd_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // Reset is synchronous, but outputs must read idle while it is held.
    if (rst) begin
      state_n   = S_IDLE;
      d_ready   = 1'b0;
      acc_en    = 1'b0;
      acc_i     = '0;
      upd_valid = 1'b0;
      busy      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bias_reg <= '0;
      upd_bias <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && start) begin
        bias_reg <= bias_in;
        cnt      <= '0;
      end
      if (state == S_ACC && d_valid) cnt <= cnt + CNT_W'(1);
      if (state == S_CALC) upd_bias <= sat_y;
    end
  end

endmodule

// File: tb/tb_bias_upd_ctrl.sv
// Directed bench for bias_upd_ctrl: three configurations sharing clk/rst,
// each driving a behavioural external accumulator.
module tb_bias_upd_ctrl;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       start;
  logic [2:0][31:0] bias_in;
  logic [2:0]       d_valid;
  logic [2:0][31:0] d_data;
  logic [2:0]       d_ready;
  logic [2:0]       acc_en;
  logic [2:0][31:0] acc_i;
  logic [2:0][31:0] acc_o;
  logic [2:0]       upd_valid;
  logic [2:0]       upd_ready;
  logic [2:0][31:0] upd_bias;
  logic [2:0]       busy;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  // 0: BATCH=4 LR=2, 1: BATCH=4 LR=0, 2: BATCH=1 LR=2
  for (genvar g = 0; g < 3; g++) begin : g_dut
    bias_upd_ctrl #(
      .WIDTH(32),
      .BATCH(g == 2 ? 1 : 4),
      .LR_SHIFT(g == 1 ? 0 : 2)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .start(start[g]),
      .bias_in(bias_in[g]),
      .d_valid(d_valid[g]),
      .d_data(d_data[g]),
      .d_ready(d_ready[g]),
      .acc_en(acc_en[g]),
      .acc_i(acc_i[g]),
      .acc_o(acc_o[g]),
      .upd_valid(upd_valid[g]),
      .upd_ready(upd_ready[g]),
      .upd_bias(upd_bias[g]),
      .busy(busy[g])
    );
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      acc_o[i] <= acc_en[i] ? acc_o[i] + acc_i[i] : acc_i[i];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic begin_batch(input int k, input int b);
    start[k]   = 1'b1;
    bias_in[k] = b;
    tick();
    start[k]   = 1'b0;
  endtask

  task automatic feed(input int k, input int d);
    d_valid[k] = 1'b1;
    d_data[k]  = d;
    tick();
    d_valid[k] = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    start     = '0;
    bias_in   = '0;
    d_valid   = '0;
    d_data    = '0;
    upd_ready = '0;
    tick();
    tick();
    chk("rst_upd_valid", 32'(upd_valid[0]), 0);
    chk("rst_d_ready", 32'(d_ready[0]), 0);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_acc_en", 32'(acc_en[0]), 0);
    chk("rst_acc_i", acc_i[0], 0);
    chk("rst_upd_bias", upd_bias[0], 0);
    rst = 1'b0;
    tick();

    // 8,8,8,8 back-to-back, bias 100 -> 92
    begin_batch(0, 100);
    chk("acc_busy", 32'(busy[0]), 1);
    chk("acc_d_ready", 32'(d_ready[0]), 1);
    d_valid[0] = 1'b1;
    d_data[0]  = 8;
    #1;
    chk("first_acc_en", 32'(acc_en[0]), 0);
    chk("first_acc_i", acc_i[0], 8);
    tick();
    #1;
    chk("second_acc_en", 32'(acc_en[0]), 1);
    d_valid[0] = 1'b0;
    feed(0, 8);
    feed(0, 8);
    feed(0, 8);
    chk("calc_upd_valid", 32'(upd_valid[0]), 0);
    chk("calc_acc_o", acc_o[0], 32);
    chk("calc_acc_en", 32'(acc_en[0]), 1);
    chk("calc_d_ready", 32'(d_ready[0]), 0);
    tick();
    chk("t2_upd_valid", 32'(upd_valid[0]), 1);
    chk("t2_upd_bias", upd_bias[0], 92);

    // consumer stall with stray start pulses
    start[0]   = 1'b1;
    bias_in[0] = 7;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 32'(upd_valid[0]), 1);
      chk("stall_bias", upd_bias[0], 92);
      chk("stall_acc_o", acc_o[0], 32);
    end
    start[0]     = 1'b0;
    upd_ready[0] = 1'b1;
    tick();
    upd_ready[0] = 1'b0;
    chk("out_idle_busy", 32'(busy[0]), 0);
    chk("out_idle_valid", 32'(upd_valid[0]), 0);

    // start in the IDLE cycle right after OUT; -4 x4 with gaps -> 104
    begin_batch(0, 100);
    chk("restart_busy", 32'(busy[0]), 1);
    feed(0, -4);
    start[0]   = 1'b1;
    bias_in[0] = 555;
    tick();
    start[0] = 1'b0;
    feed(0, -4);
    tick();
    feed(0, -4);
    tick();
    chk("gap_still_acc", 32'(d_ready[0]), 1);
    chk("gap_no_valid", 32'(upd_valid[0]), 0);
    feed(0, -4);
    chk("gap_acc_o", acc_o[0], -16);
    d_valid[0] = 1'b1;
    d_data[0]  = 1000;
    tick();
    d_valid[0] = 1'b0;
    chk("gap_upd_valid", 32'(upd_valid[0]), 1);
    chk("gap_upd_bias", upd_bias[0], 104);
    chk("gap_acc_hold", acc_o[0], -16);
    upd_ready[0] = 1'b1;
    tick();
    upd_ready[0] = 1'b0;

    // reset after 2 of 4 samples
    begin_batch(0, 100);
    feed(0, 8);
    feed(0, 8);
    rst = 1'b1;
    #1;
    chk("midrst_d_ready", 32'(d_ready[0]), 0);
    chk("midrst_busy", 32'(busy[0]), 0);
    chk("midrst_acc_en", 32'(acc_en[0]), 0);
    tick();
    chk("postrst_bias", upd_bias[0], 0);
    chk("postrst_busy", 32'(busy[0]), 0);
    chk("postrst_valid", 32'(upd_valid[0]), 0);
    chk("postrst_acc_i", acc_i[0], 0);
    rst = 1'b0;
    tick();
    chk("idle_clear_acc", acc_o[0], 0);
    begin_batch(0, 100);
    feed(0, 8);
    feed(0, 8);
    feed(0, 8);
    feed(0, 8);
    chk("fresh_acc_o", acc_o[0], 32);
    tick();
    chk("fresh_upd_bias", upd_bias[0], 92);
    upd_ready[0] = 1'b1;
    tick();
    upd_ready[0] = 1'b0;

    // saturation, LR_SHIFT=0
    begin_batch(1, -2147483647);
    for (int i = 0; i < 4; i++) feed(1, 4);
    chk("sat_lo_acc_o", acc_o[1], 16);
    tick();
    chk("sat_lo_bias", upd_bias[1], 32'h8000_0000);
    upd_ready[1] = 1'b1;
    tick();
    upd_ready[1] = 1'b0;
    begin_batch(1, 2147483646);
    for (int i = 0; i < 4; i++) feed(1, -4);
    chk("sat_hi_acc_o", acc_o[1], -16);
    tick();
    chk("sat_hi_bias", upd_bias[1], 32'h7fff_ffff);
    upd_ready[1] = 1'b1;
    tick();
    upd_ready[1] = 1'b0;

    // BATCH=1, single sample 40 -> -10
    begin_batch(2, 0);
    d_valid[2] = 1'b1;
    d_data[2]  = 40;
    #1;
    chk("b1_acc_en", 32'(acc_en[2]), 0);
    chk("b1_acc_i", acc_i[2], 40);
    tick();
    d_valid[2] = 1'b0;
    chk("b1_acc_o", acc_o[2], 40);
    chk("b1_calc_valid", 32'(upd_valid[2]), 0);
    tick();
    chk("b1_upd_valid", 32'(upd_valid[2]), 1);
    chk("b1_upd_bias", upd_bias[2], -10);
    upd_ready[2] = 1'b1;
    tick();
    upd_ready[2] = 1'b0;
    chk("b1_idle", 32'(busy[2]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
